fifo_drain: RTL and testbench
=============================

// Module: fifo_drain
// PURPOSE
// Read-side controller for the dual-clock fifo, running in the clock_out domain.
// On a start pulse it pops burst_len words through data_out/data_out_valid/data_out_ack.
// Popped words go to a downstream sink through a 2-entry skid buffer.
// Each word is checked against the rotating walking-ones stream the write side produces (1,2,4,...).
// PARAMETERS
// DATA_WIDTH  32   width of data_out and sink_data
// BURST_W     8    width of burst_len and pop_count; max burst 2^BURST_W-1
// CHECK_SEED  1    expected value of the first word after start
// PORTS
// clock_out       in   1           single clock; all logic on posedge
// rst_out         in   1           asynchronous, active-high reset
// start           in   1           1-cycle request; sampled only in IDLE
// burst_len       in   BURST_W     words to pop; latched on accepted start
// data_out        in   DATA_WIDTH  fifo head word
// data_out_valid  in   1           fifo head valid (fifo not empty)
// data_out_ack    out  1           pop request; word consumed on edge with valid&ack
// sink_data       out  DATA_WIDTH  skid-buffer head word
// sink_valid      out  1           skid buffer non-empty
// sink_ready      in   1           sink takes head on edge with valid&ready
// busy            out  1           high in RUN and DRAIN
// done            out  1           1-cycle pulse at burst completion
// pop_count       out  BURST_W     words popped in current/last burst
// mismatch        out  1           sticky: any popped word != expected
// mismatch_count  out  8           mismatching words, saturates at 255
// BEHAVIOUR
// Reset: state=IDLE; ack, sink_valid, busy, done, mismatch = 0; pop_count, mismatch_count,
//   skid count = 0; sink_data = 0; expected = CHECK_SEED. Reset mid-burst discards buffered words.
// States:
//   IDLE -> RUN on start; latches burst_len, clears pop_count/mismatch/mismatch_count,
//     loads expected = CHECK_SEED.
//   IDLE -> DONE on start with burst_len==0 (no pops).
//   RUN: data_out_ack = (skid count < 2), combinational from registered state only,
//     never from data_out_valid. Pop on edge where data_out_valid & data_out_ack.
//   RUN -> DRAIN on the edge of the pop that makes pop_count == latched burst_len.
//   DRAIN: data_out_ack = 0; DRAIN -> DONE when skid count reaches 0.
//   DONE: done = 1 for exactly one cycle -> IDLE.
//   data_out_ack = 0 in IDLE, DRAIN and DONE.
// Skid buffer (2 entries, FIFO order):
//   sink_valid = (count != 0); sink_data = head entry.
//   A word popped at edge N on an empty buffer is on sink_data from edge N onward (1-cycle latency).
//   Simultaneous pop and sink transfer: count unchanged, order preserved.
//   Sustains 1 word/cycle while sink_ready is held high.
// Checker, per pop:
//   if data_out != expected: mismatch <= 1 and mismatch_count += 1 (saturating at 255).
//   expected rotates left by 1 (MSB wraps to LSB) whether or not the word matched.
// pop_count increments by 1 per pop and holds its value in DRAIN/DONE/IDLE until the next start.
// start in RUN/DRAIN/DONE is ignored. data_out_valid low in RUN: wait indefinitely, no timeout.
// TESTING
// 1. burst_len=16, fifo always valid with 1,2,4..0x8000, sink_ready=1 -> 16 pops on 16 consecutive
//    edges; sink sees the same order; done 1 cycle after drain; mismatch=0; pop_count=16.
// 2. burst_len=4, sink_ready=0 -> ack drops after 2 pops; raise sink_ready after 5 cycles ->
//    remaining 2 pops; done pulse; no word lost or duplicated.
// 3. Third word corrupted to 0x5 -> mismatch=1, mismatch_count=1; fourth expected still 0x8.
// 4. burst_len=0 -> done one cycle after start; data_out_ack never asserted.
// 5. rst_out asserted mid-burst with 2 words buffered -> all outputs take reset values immediately;
//    a new start runs a clean burst.
// 6. DATA_WIDTH=32 with 40 words -> expected wraps from 0x80000000 to 0x1; start pulsed while busy
//    is ignored.

Source files
------------

// File: rtl/fifo_drain.sv
// Read-side controller for the dual-clock fifo: pops a burst into a 2-entry skid
// buffer feeding a sink, and checks each word against the walking-ones stream.
module fifo_drain #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    BURST_W    = 8,
  parameter logic [DATA_WIDTH-1:0] CHECK_SEED = DATA_WIDTH'(1)
) (
  input  logic                  clock_out,
  input  logic                  rst_out,
  input  logic                  start,
  input  logic [BURST_W-1:0]    burst_len,
  input  logic [DATA_WIDTH-1:0] data_out,
  input  logic                  data_out_valid,
  output logic                  data_out_ack,
  output logic [DATA_WIDTH-1:0] sink_data,
  output logic                  sink_valid,
  input  logic                  sink_ready,
  output logic                  busy,
  output logic                  done,
  output logic [BURST_W-1:0]    pop_count,
  output logic                  mismatch,
  output logic [7:0]            mismatch_count
);

  // Handshakes: a word moves on a rising edge where valid and ack/ready are both
  // high; ack is driven from registered state only, never from data_out_valid.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [BURST_W-1:0]    burst_q, burst_d;
  logic [BURST_W-1:0]    pop_count_q, pop_count_d;
  logic [DATA_WIDTH-1:0] expected_q, expected_d;
  logic                  mismatch_q, mismatch_d;
  logic [7:0]            mm_cnt_q, mm_cnt_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d, buf1_q, buf1_d;
  logic [1:0]            cnt_q, cnt_d;

  logic ack, pop, take, last_pop;

  assign ack      = (state_q == S_RUN) && (cnt_q != 2'd2);
  assign pop      = ack && data_out_valid;
  assign take     = (cnt_q != 2'd0) && sink_ready;
  assign last_pop = pop && ((pop_count_q + BURST_W'(1)) == burst_q);

  always_comb begin
    state_d     = state_q;
    burst_d     = burst_q;
    pop_count_d = pop_count_q;
    expected_d  = expected_q;
    mismatch_d  = mismatch_q;
    mm_cnt_d    = mm_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          burst_d     = burst_len;
          pop_count_d = '0;
          mismatch_d  = 1'b0;
          mm_cnt_d    = '0;
          expected_d  = CHECK_SEED;
          state_d     = (burst_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (pop) begin
          pop_count_d = pop_count_q + BURST_W'(1);
          // The expected pattern advances on every pop, matched or not.
          expected_d  = {expected_q[DATA_WIDTH-2:0], expected_q[DATA_WIDTH-1]};
          if (data_out != expected_q) begin
            mismatch_d = 1'b1;
            if (mm_cnt_q != 8'hFF) mm_cnt_d = mm_cnt_q + 8'd1;
          end
          if (last_pop) state_d = S_DRAIN;
        end
      end
      S_DRAIN: if (cnt_q == 2'd0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    buf0_d = buf0_q;
    buf1_d = buf1_q;
    cnt_d  = cnt_q;
    case ({pop, take})
      2'b11: begin
        // Count stays put; the new word lands behind whatever remains.
        if (cnt_q == 2'd1) begin
          buf0_d = data_out;
        end else begin
          buf0_d = buf1_q;
          buf1_d = data_out;
        end
      end
      2'b10: begin
        if (cnt_q == 2'd0) buf0_d = data_out;
        else               buf1_d = data_out;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        buf0_d = buf1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_out or posedge rst_out) begin
    if (rst_out) begin
      state_q     <= S_IDLE;
      burst_q     <= '0;
      pop_count_q <= '0;
      expected_q  <= CHECK_SEED;
      mismatch_q  <= 1'b0;
      mm_cnt_q    <= '0;
      buf0_q      <= '0;
      buf1_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      pop_count_q <= pop_count_d;
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      mm_cnt_q    <= mm_cnt_d;
      buf0_q      <= buf0_d;
      buf1_q      <= buf1_d;
      cnt_q       <= cnt_d;
    end
  end

  assign data_out_ack   = ack;
  assign sink_data      = buf0_q;
  assign sink_valid     = (cnt_q != 2'd0);
  assign busy           = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done           = (state_q == S_DONE);
  assign pop_count      = pop_count_q;
  assign mismatch       = mismatch_q;
  assign mismatch_count = mm_cnt_q;

endmodule

// File: tb/tb_fifo_drain.sv
// Randomised bench for fifo_drain: a fifo source model, a sink scoreboard and a
// walking-ones reference that predicts per-burst status at each done pulse.
module tb_fifo_drain;

  localparam int DW = 32;
  localparam int BW = 8;

  logic          clk = 1'b0;
  logic          rst_out = 1'b1;
  logic          start = 1'b0;
  logic [BW-1:0] burst_len = '0;
  logic [DW-1:0] data_out = '0;
  logic          data_out_valid = 1'b0;
  logic          data_out_ack;
  logic [DW-1:0] sink_data;
  logic          sink_valid;
  logic          sink_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [BW-1:0] pop_count;
  logic          mismatch;
  logic [7:0]    mismatch_count;

  fifo_drain #(.DATA_WIDTH(DW), .BURST_W(BW), .CHECK_SEED(32'h1)) dut (
    .clock_out(clk), .rst_out(rst_out), .start(start), .burst_len(burst_len),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ack(data_out_ack),
    .sink_data(sink_data), .sink_valid(sink_valid), .sink_ready(sink_ready),
    .busy(busy), .done(done), .pop_count(pop_count), .mismatch(mismatch),
    .mismatch_count(mismatch_count)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- shared bench state ----------------
  logic [DW-1:0] src_q[$];   // words sitting in the modelled fifo
  logic [DW-1:0] exp_q[$];   // words the sink must receive, in order
  int  passed = 0, total = 0;
  int  valid_pct = 100;
  int  sink_ctl = 1;         // 0 random, 1 always ready, 2 never ready
  bit  pop_pending = 1'b0;
  bit  ack_seen = 1'b0;
  bit  prev_done = 1'b0;
  int  burst_m = 0, pops_m = 0, mm_m = 0;
  int  done_seen = 0, cyc = 0, first_pop_cyc = 0, last_pop_cyc = 0;

  function automatic logic [DW-1:0] walk(input int k);
    return DW'(1) << (k % DW);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, req);
  endtask

  // ---------------- driver: fifo source and sink_ready ----------------
  initial begin : driver
    forever begin
      @(posedge clk);
      #1;
      if (pop_pending && src_q.size() > 0) void'(src_q.pop_front());
      pop_pending = 1'b0;
      if (src_q.size() > 0 && $urandom_range(0, 99) < valid_pct) begin
        data_out_valid = 1'b1;
        data_out       = src_q[0];
      end else begin
        data_out_valid = 1'b0;
        data_out       = $urandom;
      end
      case (sink_ctl)
        0:       sink_ready = 1'($urandom_range(0, 1));
        1:       sink_ready = 1'b1;
        default: sink_ready = 1'b0;
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin : monitor
    logic [DW-1:0] w;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_out) begin
        prev_done = 1'b0;
        continue;
      end
      if (data_out_ack) ack_seen = 1'b1;
      pop_pending = data_out_valid && data_out_ack;
      if (pop_pending) begin
        chk("pop_within_burst", DW'(pops_m < burst_m), DW'(1));
        exp_q.push_back(data_out);
        if (data_out != walk(pops_m)) mm_m++;
        if (pops_m == 0) first_pop_cyc = cyc;
        last_pop_cyc = cyc;
        pops_m++;
      end
      if (sink_valid && sink_ready) begin
        if (exp_q.size() == 0) begin
          chk("sink_unexpected_word", sink_data, DW'(0));
          total++;
          $display("FAIL sink_extra: word %0h with empty scoreboard", sink_data);
        end else begin
          w = exp_q.pop_front();
          chk("sink_data", sink_data, w);
        end
      end
      if (done) begin
        chk("done_single_cycle", DW'(prev_done), DW'(0));
        chk("done_busy_low", DW'(busy), DW'(0));
        chk("done_pops", DW'(pops_m), DW'(burst_m));
        chk("done_pop_count", DW'(pop_count), DW'(burst_m));
        chk("done_mismatch", DW'(mismatch), DW'(mm_m > 0));
        chk("done_mismatch_count", DW'(mismatch_count), DW'((mm_m > 255) ? 255 : mm_m));
        chk("done_drained", DW'(exp_q.size()), DW'(0));
        done_seen++;
      end
      prev_done = done;
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic fill_src(input int len, input int corrupt_idx);
    for (int k = 0; k < len; k++) src_q.push_back((k == corrupt_idx) ? DW'(5) : walk(k));
  endtask

  task automatic start_burst(input int len, input bit new_burst);
    @(posedge clk);
    #1;
    start = 1'b1;
    burst_len = BW'(len);
    if (new_burst) begin
      burst_m = len;
      pops_m  = 0;
      mm_m    = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cycles);
    int d0;
    bit got;
    d0  = done_seen;
    got = 1'b0;
    for (int i = 0; i < max_cycles && !got; i++) begin
      @(posedge clk);
      if (done_seen != d0) got = 1'b1;
    end
    chk(name, DW'(got), DW'(1));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},        DW'(data_out_ack), DW'(0));
    chk({tag, "_sink_valid"}, DW'(sink_valid), DW'(0));
    chk({tag, "_sink_data"},  sink_data, DW'(0));
    chk({tag, "_busy"},       DW'(busy), DW'(0));
    chk({tag, "_done"},       DW'(done), DW'(0));
    chk({tag, "_pop_count"},  DW'(pop_count), DW'(0));
    chk({tag, "_mismatch"},   DW'(mismatch), DW'(0));
    chk({tag, "_mm_count"},   DW'(mismatch_count), DW'(0));
  endtask

  task automatic clear_bench;
    src_q.delete();
    exp_q.delete();
    pop_pending = 1'b0;
    burst_m = 0;
    pops_m  = 0;
    mm_m    = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin : tests
    int len, cidx;
    repeat (3) @(posedge clk);
    #2;
    chk_reset_outputs("reset");
    rst_out = 1'b0;

    // Full-rate burst of 16
    valid_pct = 100; sink_ctl = 1;
    fill_src(16, -1);
    start_burst(16, 1'b1);
    wait_done("t1_done", 100);
    chk("t1_consecutive_pops", DW'(last_pop_cyc - first_pop_cyc), DW'(15));

    // Sink stalled: only two words fit before ack drops
    sink_ctl = 2;
    fill_src(4, -1);
    start_burst(4, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("t2_pops_while_stalled", DW'(pops_m), DW'(2));
    chk("t2_ack_low_when_full", DW'(data_out_ack), DW'(0));
    chk("t2_busy", DW'(busy), DW'(1));
    sink_ctl = 1;
    wait_done("t2_done", 100);

    // Third word corrupted
    sink_ctl = 0;
    fill_src(8, 2);
    start_burst(8, 1'b1);
    wait_done("t3_done", 200);
    chk("t3_one_mismatch_model", DW'(mm_m), DW'(1));

    // Zero-length burst
    ack_seen = 1'b0;
    start_burst(0, 1'b1);
    chk("t4_done_next_cycle", DW'(done), DW'(1));
    repeat (3) @(posedge clk);
    chk("t4_ack_never", DW'(ack_seen), DW'(0));

    // Reset with two words buffered
    sink_ctl = 2;
    fill_src(8, -1);
    start_burst(8, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    chk("t5_buffered_before_reset", DW'(pops_m), DW'(2));
    #2;
    rst_out = 1'b1;
    #1;
    chk_reset_outputs("t5_async");
    clear_bench();
    repeat (2) @(posedge clk);
    #3;
    rst_out = 1'b0;
    sink_ctl = 1;
    fill_src(8, -1);
    start_burst(8, 1'b1);
    wait_done("t5_clean_done", 100);

    // 40 words: walking one wraps, start while busy is ignored
    valid_pct = 70; sink_ctl = 0;
    fill_src(40, -1);
    start_burst(40, 1'b1);
    repeat (10) @(posedge clk);
    start_burst(3, 1'b0);
    wait_done("t6_done", 500);

    // Random bursts, some with one corrupted word
    for (int r = 0; r < 4; r++) begin
      len  = $urandom_range(1, 24);
      cidx = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
      valid_pct = $urandom_range(40, 100);
      fill_src(len, cidx);
      start_burst(len, 1'b1);
      wait_done("rand_done", 400);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
